// File: rtl/fwd_arbiter_pkg.sv
// Shared constants, FSM state encoding and keep-mask helper for the forwarding arbiter.
package fwd_arbiter_pkg;

  localparam int BYTES_PER_WORD = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Byte-valid mask for the final word; rem is the number of bytes past the last full word.
  function automatic logic [7:0] tail_keep(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : ~(8'hFF >> rem);
  endfunction

endpackage

// File: rtl/fwd_arb_fifo.sv
// Output FIFO: registered pointers and count, read data presented directly from the head entry.
module fwd_arb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 73
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/fwd_arbiter.sv
// Round-robin arbiter that reads one core's forwarding buffer and streams it out as a packet.
module fwd_arbiter
  import fwd_arbiter_pkg::*;
#(
  parameter int N_CORES    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64,
  parameter int PLEN_WIDTH = 13,
  parameter int BUF_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CORES-1:0]              fwd_req,
  input  logic [N_CORES*PLEN_WIDTH-1:0]   fwd_len,
  output logic [ADDR_WIDTH-1:0]           fwd_addr,
  output logic [N_CORES-1:0]              fwd_rd_en,
  input  logic [N_CORES*DATA_WIDTH-1:0]   fwd_rd_data,
  output logic [N_CORES-1:0]              fwd_done,
  output logic [63:0]                     m_tdata,
  output logic [7:0]                      m_tkeep,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  input  logic                            m_tready,
  output logic                            busy,
  output logic [$clog2(N_CORES)-1:0]      grant_id
);

  localparam int GW = $clog2(N_CORES);
  localparam int WW = PLEN_WIDTH - 2;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                r_state;
  logic [GW-1:0]         r_rr;
  logic [GW-1:0]         r_grant;
  logic [WW-1:0]         r_words;
  logic [WW-1:0]         r_widx;
  logic [2:0]            r_rem;
  logic [N_CORES-1:0]    r_rd_en;
  logic [N_CORES-1:0]    r_done;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_tag_last;
  logic [7:0]            r_tag_keep;
  logic                  r_pv    [1:BUF_LAT];
  logic                  r_plast [1:BUF_LAT];
  logic [7:0]            r_pkeep [1:BUF_LAT];
  logic [CW:0]           r_in_flight;

  logic                  w_any;
  logic [GW-1:0]         w_pick;
  logic [PLEN_WIDTH-1:0] w_len;
  logic [WW-1:0]         w_words;
  logic                  w_issue;
  logic                  w_is_last;
  logic                  w_capture;
  logic                  w_pop;
  logic [CW-1:0]         w_fifo_count;
  logic                  w_full;
  logic                  w_empty;
  logic [72:0]           w_din;
  logic [72:0]           w_dout;

  // Scan from the highest offset down so the closest requester at/after r_rr wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = N_CORES - 1; k >= 0; k--) begin
      if (fwd_req[(int'(r_rr) + k) % N_CORES]) begin
        w_any  = 1'b1;
        w_pick = GW'((int'(r_rr) + k) % N_CORES);
      end
    end
  end

  assign w_len     = fwd_len[w_pick*PLEN_WIDTH +: PLEN_WIDTH];
  assign w_words   = {1'b0, w_len[PLEN_WIDTH-1:3]} + WW'(|w_len[2:0]);
  assign w_pop     = !w_empty && m_tready;
  assign w_is_last = (r_widx == r_words - 1'b1);
  assign w_capture = r_pv[BUF_LAT];

  // Credit: queued plus outstanding words may never exceed the FIFO once this read lands.
  assign w_issue = (r_state == ST_STREAM) && (r_widx < r_words) && !w_full &&
                   ((int'(w_fifo_count) + int'(r_in_flight) - int'(w_pop)) < FIFO_DEPTH);

  assign w_din = {fwd_rd_data[r_grant*DATA_WIDTH +: 64], r_pkeep[BUF_LAT], r_plast[BUF_LAT]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rr        <= '0;
      r_grant     <= '0;
      r_words     <= '0;
      r_widx      <= '0;
      r_rem       <= '0;
      r_rd_en     <= '0;
      r_done      <= '0;
      r_addr      <= '0;
      r_tag_last  <= 1'b0;
      r_tag_keep  <= '0;
      r_in_flight <= '0;
      for (int k = 1; k <= BUF_LAT; k++) begin
        r_pv[k]    <= 1'b0;
        r_plast[k] <= 1'b0;
        r_pkeep[k] <= '0;
      end
    end else begin
      r_rd_en     <= '0;
      r_done      <= '0;
      r_in_flight <= r_in_flight + (CW+1)'(w_issue) - (CW+1)'(w_capture);
      r_pv[1]     <= |r_rd_en;
      r_plast[1]  <= r_tag_last;
      r_pkeep[1]  <= r_tag_keep;
      for (int k = 2; k <= BUF_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_plast[k] <= r_plast[k-1];
        r_pkeep[k] <= r_pkeep[k-1];
      end
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_words <= w_words;
            r_rem   <= w_len[2:0];
            r_widx  <= '0;
            if (w_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= N_CORES'(1) << w_pick;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_rd_en    <= N_CORES'(1) << r_grant;
            r_addr     <= ADDR_WIDTH'(r_widx);
            r_widx     <= r_widx + 1'b1;
            r_tag_last <= w_is_last;
            r_tag_keep <= w_is_last ? tail_keep(r_rem) : 8'hFF;
            if (w_is_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (r_in_flight == '0 && w_empty) begin
            r_state <= ST_DONE;
            r_done  <= N_CORES'(1) << r_grant;
          end
        end
        ST_DONE: begin
          r_rr    <= (r_grant == GW'(N_CORES - 1)) ? '0 : r_grant + 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  fwd_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (73)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_capture),
    .din   (w_din),
    .pop   (w_pop),
    .dout  (w_dout),
    .count (w_fifo_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign m_tvalid  = !w_empty;
  assign m_tdata   = w_empty ? '0 : w_dout[72:9];
  assign m_tkeep   = w_empty ? '0 : w_dout[8:1];
  assign m_tlast   = w_empty ? 1'b0 : w_dout[0];
  assign fwd_addr  = r_addr;
  assign fwd_rd_en = r_rd_en;
  assign fwd_done  = r_done;
  assign busy      = (r_state != ST_IDLE);
  assign grant_id  = r_grant;

endmodule

// File: tb/tb_fwd_arbiter.sv
// Scoreboard bench for fwd_arbiter: packet-level reference model feeds expected beats and grants.
module tb_fwd_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int PW = 13;
  localparam int BL = 2;
  localparam int FD = 4;

  typedef struct {
    int          core;
    int          len;
    logic [31:0] salt;
  } pkt_t;

  typedef struct {
    int core;
    int words;
  } exp_pkt_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      fwd_req;
  logic [N*PW-1:0]   fwd_len;
  logic [AW-1:0]     fwd_addr;
  logic [N-1:0]      fwd_rd_en;
  logic [N*DW-1:0]   fwd_rd_data;
  logic [N-1:0]      fwd_done;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic              busy;
  logic [1:0]        grant_id;

  logic [72:0] exp_q[$];
  exp_pkt_t    exp_pkt_q[$];
  pkt_t        pend_q[$];

  int          n_vec = 0;
  int          n_fail = 0;
  int          model_rr = 0;
  int          cyc = 0;
  int          phase = 0;
  int          tready_mode = 0;
  logic [N-1:0] active;
  int          raise_cyc [N];
  logic [31:0] cur_salt [N];
  int          reads_in_pkt = 0;
  int          beats_in_pkt = 0;
  int          reads_total = 0;
  int          beats_total = 0;
  int          last_latency = 0;
  bit          prev_stall = 1'b0;
  logic [72:0] prev_beat;

  logic [N-1:0]  mp_en   [BL];
  logic [AW-1:0] mp_addr [BL];

  fwd_arbiter #(
    .N_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .PLEN_WIDTH(PW), .BUF_LAT(BL), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .fwd_req(fwd_req), .fwd_len(fwd_len),
    .fwd_addr(fwd_addr), .fwd_rd_en(fwd_rd_en), .fwd_rd_data(fwd_rd_data),
    .fwd_done(fwd_done), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .busy(busy), .grant_id(grant_id)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- buffer memory model (fixed read latency) ----------------
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    mp_en[0]   <= fwd_rd_en;
    mp_addr[0] <= fwd_addr;
    for (int k = 1; k < BL; k++) begin
      mp_en[k]   <= mp_en[k-1];
      mp_addr[k] <= mp_addr[k-1];
    end
  end

  always_comb begin
    fwd_rd_data = '0;
    for (int c = 0; c < N; c++) begin
      if (mp_en[BL-1][c] === 1'b1)
        fwd_rd_data[c*DW +: DW] = {cur_salt[c], 16'(c), 16'(mp_addr[BL-1])};
      else
        fwd_rd_data[c*DW +: DW] = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // ---------------- tready driver ----------------
  always @(negedge clk) begin
    case (tready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = ((phase % 4) == 0) || ((phase % 4) == 3);
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
    phase++;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},   73'(fwd_rd_en), '0);
    check({tag, "_done"},    73'(fwd_done),  '0);
    check({tag, "_tvalid"},  73'(m_tvalid),  '0);
    check({tag, "_tlast"},   73'(m_tlast),   '0);
    check({tag, "_busy"},    73'(busy),      '0);
    check({tag, "_grant"},   73'(grant_id),  '0);
    check({tag, "_addr"},    73'(fwd_addr),  '0);
    check({tag, "_tdata"},   73'(m_tdata),   '0);
    check({tag, "_tkeep"},   73'(m_tkeep),   '0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [72:0] beat;
    #3;
    if (rst === 1'b1) begin
      beat = {m_tdata, m_tkeep, m_tlast};
      if (prev_stall) begin
        check("stall_valid", 73'(m_tvalid), 73'(1));
        check("stall_hold", beat, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else check("beat", beat, exp_q.pop_front());
        beats_in_pkt++;
        beats_total++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = beat;
      if (|fwd_rd_en) begin
        if (exp_pkt_q.size() == 0) fail_now("unexpected_read");
        else begin
          check("rd_en_core", 73'(fwd_rd_en), 73'(1 << exp_pkt_q[0].core));
          check("rd_addr", 73'(fwd_addr), 73'(reads_in_pkt));
          check("rd_in_range", 73'(reads_in_pkt < exp_pkt_q[0].words), 73'(1));
          reads_in_pkt++;
          reads_total++;
          check("credit_limit", 73'((reads_total - beats_total) <= FD), 73'(1));
        end
      end
      if (|fwd_done) begin
        if (exp_pkt_q.size() == 0) fail_now("unexpected_done");
        else begin
          check("done_core", 73'(fwd_done), 73'(1 << exp_pkt_q[0].core));
          check("grant_id", 73'(grant_id), 73'(exp_pkt_q[0].core));
          check("done_after_last", 73'(beats_in_pkt), 73'(exp_pkt_q[0].words));
          void'(exp_pkt_q.pop_front());
        end
        reads_in_pkt = 0;
        beats_in_pkt = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic add_pkt(input int c, input int len);
    pkt_t p;
    p.core = c;
    p.len  = len;
    p.salt = $urandom();
    pend_q.push_back(p);
  endtask

  // Each core serves its own packets in order; the arbiter takes the first core with work at/after rr.
  task automatic model_batch();
    pkt_t sim[$];
    sim = pend_q;
    while (sim.size() > 0) begin
      int   idx;
      pkt_t p;
      int   words;
      exp_pkt_t e;
      idx = -1;
      for (int k = 0; k < N && idx < 0; k++) begin
        for (int j = 0; j < sim.size() && idx < 0; j++)
          if (sim[j].core == (model_rr + k) % N) idx = j;
      end
      p = sim[idx];
      sim.delete(idx);
      words = (p.len + 7) / 8;
      for (int w = 0; w < words; w++) begin
        int         bytes;
        logic [7:0] ones;
        logic [7:0] keep;
        ones  = 8'hFF;
        bytes = (w == words - 1) ? p.len - 8 * w : 8;
        keep  = ones << (8 - bytes);
        exp_q.push_back({p.salt, 16'(p.core), 16'(w), keep, (w == words - 1)});
      end
      e.core  = p.core;
      e.words = words;
      exp_pkt_q.push_back(e);
      model_rr = (p.core + 1) % N;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic raise_next(input int c);
    int idx;
    idx = -1;
    for (int j = 0; j < pend_q.size() && idx < 0; j++)
      if (pend_q[j].core == c) idx = j;
    if (idx >= 0) begin
      fwd_req[c]           = 1'b1;
      fwd_len[c*PW +: PW]  = PW'(pend_q[idx].len);
      cur_salt[c]          = pend_q[idx].salt;
      active[c]            = 1'b1;
      raise_cyc[c]         = cyc;
      pend_q.delete(idx);
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_pkt_q.delete();
    reads_in_pkt = 0;
    beats_in_pkt = 0;
    reads_total  = 0;
    beats_total  = 0;
    prev_stall   = 1'b0;
  endtask

  task automatic wait_batch(input int budget);
    int t;
    t = 0;
    while (!(pend_q.size() == 0 && active == '0 && exp_pkt_q.size() == 0)) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (active[c] && fwd_done[c]) begin
          last_latency = cyc - raise_cyc[c];
          active[c]    = 1'b0;
          fwd_req[c]   = 1'b0;
          raise_next(c);
        end
      end
      t++;
      if (t > budget) begin
        fail_now("batch_timeout");
        fwd_req = '0;
        active  = '0;
        pend_q.delete();
        flush_model();
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_batch(input int mode, input int budget);
    tready_mode = mode;
    model_batch();
    for (int c = 0; c < N; c++) if (!active[c]) raise_next(c);
    wait_batch(budget);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    pkt_t rp;
    int   t;
    rst      = 1'b0;
    fwd_req  = '0;
    fwd_len  = '0;
    active   = '0;
    m_tready = 1'b1;
    for (int c = 0; c < N; c++) begin
      cur_salt[c]  = '0;
      raise_cyc[c] = 0;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;

    // round robin over cores 0,1,3, each with two 8-byte packets
    for (int r = 0; r < 2; r++) begin
      add_pkt(0, 8);
      add_pkt(1, 8);
      add_pkt(3, 8);
    end
    run_batch(0, 500);

    // single 20-byte packet
    add_pkt(0, 20);
    run_batch(0, 200);

    // backpressure on an 8-word packet
    add_pkt(2, 64);
    run_batch(1, 400);

    // zero length
    add_pkt(2, 0);
    run_batch(0, 50);
    check("zero_len_latency", 73'(last_latency <= 3), 73'(1));

    // length boundaries
    add_pkt(0, 1);
    add_pkt(1, 8);
    add_pkt(3, 9);
    run_batch(0, 300);

    // asynchronous reset in the middle of a 5-word packet
    add_pkt(1, 40);
    rp = pend_q[0];
    tready_mode = 0;
    model_batch();
    raise_next(1);
    t = 0;
    while (beats_in_pkt < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail_now("reset_wait_timeout");
    #1 rst = 1'b0;
    #1 check_outputs_zero("async_reset");
    flush_model();
    model_rr = 0;
    repeat (2) @(negedge clk);
    check_outputs_zero("held_reset");
    rst = 1'b1;
    pend_q.push_back(rp);
    model_batch();
    pend_q.delete();
    wait_batch(300);

    // randomized mix
    for (int i = 0; i < 12; i++) add_pkt($urandom_range(0, N - 1), $urandom_range(0, 70));
    run_batch(2, 3000);

    check("exp_q_empty", 73'(exp_q.size()), 73'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_arbiter.md
Name: fwd_arbiter

Overview:
- Shares one downstream forwarder among N_CORES packet filter cores. Each core's forwarding buffer holds an accepted packet.
- The block picks one requesting core round-robin and reads its buffer word by word through a fixed-latency read port.
- It streams the words out as an AXI-Stream-like packet with tkeep/tlast, then pulses that core's done to release its buffer.
- It sits between the per-core forwarding adapters and the single output forwarder.

Parameters:
- N_CORES, 4: number of requesting cores (2..16).
- ADDR_WIDTH, 10: buffer word-address width.
- DATA_WIDTH, 64: buffer/stream word width (fixed at 64; 8 bytes per word).
- PLEN_WIDTH, 13: packet byte-length width.
- BUF_LAT, 2: cycles from fwd_rd_en/fwd_addr to valid fwd_rd_data.
- FIFO_DEPTH, 4: output FIFO entries; must be at least BUF_LAT+2.

Ports:
- clk  in  1: single clock, all logic on posedge.
- rst  in  1: asynchronous, active-low reset.
- fwd_req  in  N_CORES: core i holds a packet ready; held until fwd_done[i].
- fwd_len  in  N_CORES*PLEN_WIDTH: byte length per core, slice i valid while fwd_req[i].
- fwd_addr  out  ADDR_WIDTH: shared read word address.
- fwd_rd_en  out  N_CORES: one-hot read strobe to the granted core.
- fwd_rd_data  in  N_CORES*DATA_WIDTH: read data per core.
- fwd_done  out  N_CORES: one-cycle pulse releasing the granted buffer.
- m_tdata  out  64: stream data; first packet byte in [63:56].
- m_tkeep  out  8: byte valid; bit 7 corresponds to [63:56].
- m_tvalid  out  1: stream valid.
- m_tlast  out  1: last beat of the packet.
- m_tready  in  1: stream ready.
- busy  out  1: high in any state other than IDLE.
- grant_id  out  $clog2(N_CORES): currently granted core.

Behaviour:
- Reset (rst low, async): state IDLE, rr pointer 0, FIFO empty, in-flight count 0.
  - All outputs are 0: fwd_rd_en, fwd_done, m_tvalid, m_tlast, busy, grant_id, fwd_addr, m_tdata, m_tkeep.
  - Reset mid-packet drops all in-flight and queued data. No fwd_done is pulsed.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE:
  - If any fwd_req bit is set, grant the first set bit at or after the rr pointer, wrapping around.
  - Latch grant_id and len. Compute words = ceil(len/8). Set addr=0. Next state STREAM.
  - If len==0, go directly to DONE; no beats and no reads are issued.
- STREAM:
  - Issue a read (fwd_rd_en[grant]=1, fwd_addr=addr, addr++) when addr < words and fifo_count + in_flight < FIFO_DEPTH.
  - After issuing the read for word words-1, go to DRAIN.
- Read return: a read issued at cycle t is captured into the FIFO at t+BUF_LAT from the fwd_rd_data slice of the grant.
  - Each captured word is tagged last/keep:
    - last = (word index == words-1).
    - keep = 8'hFF, except the last word when len%8 != 0, where keep = the top (len%8) bits set. Example: len%8=3 gives 8'hE0.
- Output:
  - m_tvalid = FIFO non-empty. A beat pops on m_tvalid && m_tready.
  - m_tdata, m_tkeep and m_tlast must hold stable while m_tvalid && !m_tready.
- DRAIN: wait for in_flight==0 and the FIFO empty (tlast beat accepted), then go to DONE.
- DONE:
  - fwd_done[grant]=1 for exactly one cycle. rr pointer = grant+1 mod N_CORES. Next state IDLE.
  - A new grant is made no earlier than the cycle after DONE.
- fwd_req changes during a packet are ignored. The arbiter samples fwd_req only in IDLE.
- Simultaneous FIFO push and pop in the same cycle leave fifo_count unchanged.
- The FIFO never overflows, by the credit rule.
- Throughput with m_tready held high: one beat per cycle after an initial BUF_LAT+1 cycle latency.

Decomposition:
- Shared package/header: BYTES_PER_WORD=8 and the state encodings (IDLE=0, STREAM=1, DRAIN=2, DONE=3).
- One sub-module: fwd_arb_fifo, a synchronous FIFO of FIFO_DEPTH entries by 64+8+1 bits.
  - Ports: push, pop, count, full, empty.
  - Same clk and async active-low rst as the parent.

Test Plan:
- Single packet: fwd_req=4'b0001, len=20, m_tready=1.
  - 3 beats: keep FF, FF, F0; tlast on beat 3.
  - fwd_rd_en[0] asserted at addr 0,1,2. fwd_done[0] pulses once after tlast is accepted.
- Round-robin: fwd_req=4'b1011 held (each re-raised after done), len=8.
  - Grant order 0,1,3,0,1,3. Each packet is 1 beat with keep=FF and tlast=1.
- Backpressure: len=64 (8 words); m_tready toggles 1,0,0,1 repeating.
  - All 8 words arrive in order with no loss and no duplicates.
  - fifo_count + in_flight never exceeds 4. Data stays stable while stalled.
- Zero length: fwd_req[2]=1, len=0.
  - No m_tvalid and no fwd_rd_en. fwd_done[2] pulses within 3 cycles of the request.
- Reset mid-packet: rst low during beat 2 of a 5-word packet.
  - All outputs read 0 immediately (async). No fwd_done pulse.
  - After rst goes high with fwd_req still set, the packet restarts from addr 0.
- Length boundaries: len=1 gives keep=80 and 1 beat. len=8 gives keep=FF. len=9 gives 2 beats with last keep=80.
